uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
Serial UART transmitter, 8N1 by default, with an internal bit-period counter. Accepts a parallel byte over a valid/ready handshake and shifts it out LSB-first on a single line that idles high. It is the transmit end of the same 115200-baud link the receive-side timing helpers serve. It runs from the 100 MHz system clock with no derived clocks.

Parameters:
CLKS_PER_BIT, 868, system clocks per serial bit (100 MHz / 115200); legal range 2..2^20-1.
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY_EN, 0, 1 = insert a parity bit after the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
STOP_BITS, 1, stop bits per frame; 1 or 2.

Ports:
clock  input  1  system clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
tx_data  input  DATA_BITS  byte to send; sampled only on an accept.
tx_valid  input  1  tx_data is valid.
tx_ready  output  1  block can accept; accept = tx_valid && tx_ready at a rising edge.
tx  output  1  serial line; idles high.
busy  output  1  high from the accept edge until the frame ends.
tx_done  output  1  one-cycle pulse after the last stop bit completes.

Behaviour:
- Reset (synchronous, active-high): the reset values below apply at the first edge with reset=1 and hold while reset stays high.
  - tx=1, tx_ready=0, busy=0, tx_done=0.
  - State = IDLE, bit counter = 0, shift register = 0.
  - tx_ready rises at the first edge after reset deasserts.
- Reset mid-frame aborts the frame: tx returns high at that edge, and no tx_done is produced.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1, tx_ready=1, busy=0.
  - On accept: latch tx_data into the shift register, and compute parity as the XOR of the data bits, XORed with PARITY_ODD.
  - At that same edge: tx_ready becomes 0, busy becomes 1, tx becomes 0, state goes to START, and the baud counter loads CLKS_PER_BIT-1.
- Bit timing: every bit is held exactly CLKS_PER_BIT cycles. The counter decrements each cycle; when it reaches 0 it reloads CLKS_PER_BIT-1 and the next bit is driven.
- START -> DATA: send bit 0 (LSB) first, then bits 1..DATA_BITS-1. A bit index counter tracks position.
- After the last data bit: go to PARITY if PARITY_EN=1, otherwise to STOP.
- PARITY: one bit period, then STOP.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. At the end:
  - State goes to IDLE, tx_done=1 for one cycle, busy=0, tx_ready=1 at that same edge.
- Frame length from the first low cycle of tx to the tx_done edge is (1 + DATA_BITS + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles.
- Back-to-back: if tx_valid is high in the tx_done cycle, the next accept occurs at that edge. The next start bit therefore follows the last stop bit with exactly 1 extra idle-high clock.
- Ignored inputs:
  - tx_valid while tx_ready=0 is ignored.
  - Changes to tx_data after the accept do not affect the frame in flight.
- Width rules:
  - Baud counter width = clog2(CLKS_PER_BIT).
  - Bit index width = clog2(DATA_BITS).
  - STOP uses the bit index to count stop bits.
- Illegal states recover to IDLE with tx=1.

Decomposition:
- Shared package uart_pkg holds:
  - the state enumeration (IDLE, START, DATA, PARITY, STOP) as 3-bit localparams;
  - DEFAULT_CLKS_PER_BIT = 868;
  - the IDLE_LEVEL = 1'b1 constant.
  The future uart_rx reuses this package.
- One sub-module, uart_baud_tick, is natural:
  - ports: clock, reset, restart, tick;
  - a counter that reloads CLKS_PER_BIT-1 on restart or at zero;
  - tick is high in the cycle the count is 0.
  The FSM consumes tick.

Test Plan:
All tests use CLKS_PER_BIT=16.
- Defaults, send 0xA5: tx sequence 0,1,0,1,0,0,1,0,1,1 with each level held 16 cycles. tx_done pulses once, 160 cycles after tx falls. tx_ready=0 throughout the frame.
- PARITY_EN=1, PARITY_ODD=0, send 0x07: parity bit=1, frame 176 cycles. With PARITY_ODD=1 and data 0x07, parity bit=0.
- tx_valid held high with 0x55 then 0x0F: the two frames are separated by exactly 1 idle-high clock. Both decode correctly and tx_done pulses twice.
- Assert reset for 1 cycle at cycle 40 of a frame: at that edge tx=1, busy=0 and no tx_done. tx_ready=1 at the next edge. A following 0x3C is sent intact.
- During a frame, drive tx_valid=1 with tx_data=0xFF: there is no accept and the in-flight byte 0x12 is unchanged. Changing tx_data the cycle after accept does not alter the output.
- STOP_BITS=2, DATA_BITS=7, send 0x41: stop-high period is 32 cycles and total frame is 160 cycles. Bit 7 is never driven.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, default baud divisor and line idle level.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_if.sv
// Parallel byte handshake into the UART transmitter.
interface uart_tx_if #(
  parameter int unsigned DATA_BITS = 8
);

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: reloads CLKS_PER_BIT-1 on restart or at zero; tick marks the zero cycle.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (restart || (count == '0)) begin
      count <= RELOAD;
    end else begin
      count <= count - CNT_W'(1);
    end
  end

  assign tick = (count == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts a word over valid/ready and shifts it out LSB-first
// with optional parity and one or two stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic      clock,
  input  logic      reset,
  uart_tx_if.slave  bus,
  output logic      tx,
  output logic      busy,
  output logic      tx_done
);

  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  logic [2:0]           state;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 parity_bit;
  logic                 ready_q;
  logic                 accept;
  logic                 tick;

  assign bus.tx_ready = ready_q;
  assign accept       = bus.tx_valid && ready_q;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clock  (clock),
    .reset  (reset),
    .restart(accept),
    .tick   (tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      bit_idx    <= '0;
      shreg      <= '0;
      parity_bit <= 1'b0;
      tx         <= IDLE_LEVEL;
      ready_q    <= 1'b0;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          tx   <= IDLE_LEVEL;
          busy <= 1'b0;
          if (accept) begin
            shreg      <= bus.tx_data;
            parity_bit <= (^bus.tx_data) ^ PARITY_ODD[0];
            tx         <= ~IDLE_LEVEL;
            ready_q    <= 1'b0;
            busy       <= 1'b1;
            bit_idx    <= '0;
            state      <= ST_START;
          end else begin
            ready_q <= 1'b1;
          end
        end
        // The shift register always presents the next bit at [0]; bit_idx only counts.
        ST_START: begin
          if (tick) begin
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= '0;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
              if (PARITY_EN != 0) begin
                tx    <= parity_bit;
                state <= ST_PARITY;
              end else begin
                tx    <= IDLE_LEVEL;
                state <= ST_STOP;
              end
            end else begin
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            tx      <= IDLE_LEVEL;
            bit_idx <= '0;
            state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (bit_idx == LAST_STOP) begin
              state   <= ST_IDLE;
              tx_done <= 1'b1;
              busy    <= 1'b0;
              ready_q <= 1'b1;
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          tx      <= IDLE_LEVEL;
          busy    <= 1'b0;
          ready_q <= 1'b0;
          bit_idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four configurations at 16 clocks per bit, checked cycle by cycle
// against an expected line-level frame built from the data word.
module tb_uart_tx;

  localparam int N = 16;
  // Per-configuration: data bits, parity enable, parity odd, stop bits.
  localparam int DB[4] = '{8, 8, 8, 7};
  localparam int PE[4] = '{0, 1, 1, 0};
  localparam int PO[4] = '{0, 0, 1, 0};
  localparam int SB[4] = '{1, 1, 1, 2};

  logic       clock = 1'b0;
  logic       reset;
  logic       valid;
  logic [8:0] tb_data;
  int         sel;

  logic tx_o[4];
  logic busy_o[4];
  logic done_o[4];
  logic ready_o[4];

  int checks = 0;
  int errors = 0;
  logic exp_q[$];

  always #5 clock = ~clock;

  uart_tx_if #(.DATA_BITS(8)) if_a ();
  uart_tx_if #(.DATA_BITS(8)) if_pe ();
  uart_tx_if #(.DATA_BITS(8)) if_po ();
  uart_tx_if #(.DATA_BITS(7)) if_s ();

  assign if_a.tx_data   = tb_data[7:0];
  assign if_pe.tx_data  = tb_data[7:0];
  assign if_po.tx_data  = tb_data[7:0];
  assign if_s.tx_data   = tb_data[6:0];
  assign if_a.tx_valid  = valid && (sel == 0);
  assign if_pe.tx_valid = valid && (sel == 1);
  assign if_po.tx_valid = valid && (sel == 2);
  assign if_s.tx_valid  = valid && (sel == 3);
  assign ready_o[0] = if_a.tx_ready;
  assign ready_o[1] = if_pe.tx_ready;
  assign ready_o[2] = if_po.tx_ready;
  assign ready_o[3] = if_s.tx_ready;

  uart_tx #(.CLKS_PER_BIT(N)) dut_a (
    .clock(clock), .reset(reset), .bus(if_a),
    .tx(tx_o[0]), .busy(busy_o[0]), .tx_done(done_o[0]));

  uart_tx #(.CLKS_PER_BIT(N), .PARITY_EN(1), .PARITY_ODD(0)) dut_pe (
    .clock(clock), .reset(reset), .bus(if_pe),
    .tx(tx_o[1]), .busy(busy_o[1]), .tx_done(done_o[1]));

  uart_tx #(.CLKS_PER_BIT(N), .PARITY_EN(1), .PARITY_ODD(1)) dut_po (
    .clock(clock), .reset(reset), .bus(if_po),
    .tx(tx_o[2]), .busy(busy_o[2]), .tx_done(done_o[2]));

  uart_tx #(.CLKS_PER_BIT(N), .DATA_BITS(7), .STOP_BITS(2)) dut_s (
    .clock(clock), .reset(reset), .bus(if_s),
    .tx(tx_o[3]), .busy(busy_o[3]), .tx_done(done_o[3]));

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    check(tag, {8'd0, obs}, {8'd0, exp});
  endtask

  // Expected line levels, one entry per bit period.
  task automatic build_frame(input int s, input logic [8:0] d);
    int ones;
    ones = 0;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < DB[s]; i++) begin
      exp_q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (PE[s] != 0) exp_q.push_back(((ones + PO[s]) % 2) == 1);
    for (int i = 0; i < SB[s]; i++) exp_q.push_back(1'b1);
  endtask

  // Present d with valid high; returns at the falling edge just before the accepting edge.
  task automatic start(input logic [8:0] d);
    int t;
    t = 0;
    @(negedge clock);
    tb_data = d;
    valid   = 1'b1;
    while (!ready_o[sel] && t < 400) begin
      @(negedge clock);
      t++;
    end
    check_bit("accept_wait", ready_o[sel], 1'b1);
  endtask

  // mode 0: drop valid after accept; 1: also poke 0xFF mid-frame; 2: keep valid with nxt.
  task automatic expect_frame(input int mode, input logic [8:0] d, input logic [8:0] nxt);
    int n;
    build_frame(sel, d);
    n = exp_q.size() * N;
    for (int c = 1; c <= n; c++) begin
      @(negedge clock);
      check_bit($sformatf("s%0d_d%0h_tx_bit%0d_c%0d", sel, d, (c - 1) / N, c), tx_o[sel], exp_q[(c - 1) / N]);
      check_bit("busy_in_frame", busy_o[sel], 1'b1);
      check_bit("ready_in_frame", ready_o[sel], 1'b0);
      check_bit("done_in_frame", done_o[sel], 1'b0);
      if (c == 1) begin
        if (mode == 2) tb_data = nxt;
        else begin
          valid   = 1'b0;
          tb_data = 9'($urandom);
        end
      end
      if (mode == 1 && c == 3 * N) begin
        valid   = 1'b1;
        tb_data = '1;
      end
      if (mode == 1 && c == n) valid = 1'b0;
    end
    @(negedge clock);
    check_bit("done_pulse", done_o[sel], 1'b1);
    check_bit("ready_at_done", ready_o[sel], 1'b1);
    check_bit("busy_at_done", busy_o[sel], 1'b0);
    check_bit("tx_idle_at_done", tx_o[sel], 1'b1);
    if (mode != 2) begin
      @(negedge clock);
      check_bit("done_single", done_o[sel], 1'b0);
      check_bit("tx_idle_after", tx_o[sel], 1'b1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] d;
    reset   = 1'b1;
    valid   = 1'b0;
    tb_data = '0;
    sel     = 0;
    repeat (3) @(negedge clock);
    for (int s = 0; s < 4; s++) begin
      check_bit($sformatf("rst_tx_s%0d", s), tx_o[s], 1'b1);
      check_bit($sformatf("rst_ready_s%0d", s), ready_o[s], 1'b0);
      check_bit($sformatf("rst_busy_s%0d", s), busy_o[s], 1'b0);
      check_bit($sformatf("rst_done_s%0d", s), done_o[s], 1'b0);
    end
    reset = 1'b0;
    @(negedge clock);
    for (int s = 0; s < 4; s++) check_bit($sformatf("ready_after_rst_s%0d", s), ready_o[s], 1'b1);

    // 8N1 with 0xA5
    sel = 0;
    start(9'h0A5);
    expect_frame(0, 9'h0A5, 9'h0);

    // Even then odd parity on 0x07
    sel = 1;
    start(9'h007);
    expect_frame(0, 9'h007, 9'h0);
    sel = 2;
    start(9'h007);
    expect_frame(0, 9'h007, 9'h0);

    // Back-to-back 0x55 then 0x0F with valid held high
    sel = 0;
    start(9'h055);
    expect_frame(2, 9'h055, 9'h00F);
    expect_frame(0, 9'h00F, 9'h0);

    // Reset at cycle 40 of a frame, then an intact 0x3C
    sel = 0;
    d = 9'($urandom);
    start(d);
    build_frame(0, d);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      check_bit($sformatf("abort_tx_c%0d", c), tx_o[0], exp_q[(c - 1) / N]);
      if (c == 1) valid = 1'b0;
    end
    reset = 1'b1;
    @(negedge clock);
    check_bit("abort_tx", tx_o[0], 1'b1);
    check_bit("abort_busy", busy_o[0], 1'b0);
    check_bit("abort_done", done_o[0], 1'b0);
    check_bit("abort_ready", ready_o[0], 1'b0);
    reset = 1'b0;
    @(negedge clock);
    check_bit("abort_ready_back", ready_o[0], 1'b1);
    check_bit("abort_no_done", done_o[0], 1'b0);
    start(9'h03C);
    expect_frame(0, 9'h03C, 9'h0);

    // In-flight 0x12 with a 0xFF offered mid-frame
    sel = 0;
    start(9'h012);
    expect_frame(1, 9'h012, 9'h0);

    // 7 data bits, 2 stop bits
    sel = 3;
    start(9'h041);
    expect_frame(0, 9'h041, 9'h0);

    // Random words across all configurations
    for (int i = 0; i < 8; i++) begin
      sel = int'($urandom_range(0, 3));
      d = 9'($urandom);
      start(d);
      expect_frame(0, d, 9'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
